// File: rtl/core_trace_sink.sv
// Retirement/debug trace sink: FIFOs committed instructions and memory-sweep dump records onto one stream.
// Optional TRACE_SINK_DROP_CNT_EN adds a saturating dropped-commit counter on drop_cnt_o.
module core_trace_sink #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [4:0]      reg_addr_i,
   input  logic [XLEN-1:0] reg_data_i,
   input  logic            stall_i,
   output logic [XLEN-1:0] addr_o,
   input  logic [XLEN-1:0] data_i,
   input  logic            dump_start_i,
   input  logic [XLEN-1:0] dump_base_i,
   input  logic [15:0]     dump_len_i,
   output logic            trc_valid_o,
   input  logic            trc_ready_i,
   output logic            trc_kind_o,
   output logic [XLEN-1:0] trc_pc_o,
   output logic [XLEN-1:0] trc_instr_o,
   output logic [4:0]      trc_rd_o,
   output logic [XLEN-1:0] trc_data_o,
   output logic            busy_o,
   output logic            overflow_o
`ifdef TRACE_SINK_DROP_CNT_EN
   ,
   output logic [15:0]     drop_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef struct packed {
      logic            kind;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } rec_t;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            overflow_q, overflow_d;
   rec_t            mem_q [DEPTH];
   rec_t            push_rec, head_rec;
   logic            commit_vld, pop, room, push, dump_push, drop;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      commit_vld = !stall_i && (instr_i != '0);
      pop        = (count_q != '0) && trc_ready_i;
      room       = (count_q != DEPTH_C) || pop;
      drop       = commit_vld && !room;
      dump_push  = (state_q == SWEEP) && !commit_vld && room;
      push       = (commit_vld && room) || dump_push;

      push_rec = '{kind: 1'b0, pc: pc_i, instr: instr_i, rd: reg_addr_i, data: reg_data_i};
      if (!commit_vld) push_rec = '{kind: 1'b1, pc: addr_q, instr: '0, rd: '0, data: data_i};

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;

      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (dump_start_i && (dump_len_i != '0)) begin
               state_d = SWEEP;
               addr_d  = dump_base_i & ~XLEN'(3);
               cnt_d   = dump_len_i;
            end
         end
         SWEEP: begin
            if (dump_push) begin
               addr_d = addr_q + XLEN'(4);
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == 16'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: FIFO storage is not reset; outputs are masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= push_rec;
   end

   assign head_rec    = mem_q[rd_ptr_q];
   assign trc_valid_o = (count_q != '0);
   assign addr_o      = addr_q;
   assign busy_o      = (state_q == SWEEP);
   assign overflow_o  = overflow_q;

   always_comb begin
      trc_kind_o  = 1'b0;
      trc_pc_o    = '0;
      trc_instr_o = '0;
      trc_rd_o    = '0;
      trc_data_o  = '0;
      if (trc_valid_o) begin
         trc_kind_o  = head_rec.kind;
         trc_pc_o    = head_rec.pc;
         trc_instr_o = head_rec.instr;
         trc_rd_o    = head_rec.rd;
         trc_data_o  = head_rec.data;
      end
   end

`ifdef TRACE_SINK_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_core_trace_sink.sv
// Self-checking bench for core_trace_sink: directed scenarios plus a random phase against a queue model.
module tb_core_trace_sink;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;

   logic            clk_i, rst_i;
   logic [XLEN-1:0] pc_i, instr_i, reg_data_i, addr_o, data_i, dump_base_i;
   logic [4:0]      reg_addr_i, trc_rd_o;
   logic            stall_i, dump_start_i, trc_valid_o, trc_ready_i, trc_kind_o, busy_o, overflow_o;
   logic [15:0]     dump_len_i;
   logic [XLEN-1:0] trc_pc_o, trc_instr_o, trc_data_o;
`ifdef TRACE_SINK_DROP_CNT_EN
   logic [15:0]     drop_cnt_o;
`endif

   core_trace_sink #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
      .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .stall_i(stall_i),
      .addr_o(addr_o), .data_i(data_i), .dump_start_i(dump_start_i),
      .dump_base_i(dump_base_i), .dump_len_i(dump_len_i),
      .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_kind_o(trc_kind_o),
      .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_rd_o(trc_rd_o),
      .trc_data_o(trc_data_o), .busy_o(busy_o), .overflow_o(overflow_o)
`ifdef TRACE_SINK_DROP_CNT_EN
      , .drop_cnt_o(drop_cnt_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Bench-owned data memory, read combinationally from addr_o.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction
   assign data_i = mem_word(addr_o);

   typedef struct {
      bit        kind;
      bit [31:0] pc;
      bit [31:0] instr;
      bit [4:0]  rd;
      bit [31:0] data;
   } rec_t;

   rec_t      q[$];
   bit        m_sweep, m_ovf;
   bit [31:0] m_addr;
   int        m_rem, m_drops;
   int        n_pass, n_total;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      q.delete();
      m_sweep = 0; m_ovf = 0; m_addr = '0; m_rem = 0; m_drops = 0;
   endtask

   task automatic check_outputs();
      check("valid", trc_valid_o, q.size() != 0);
      if (q.size() != 0) begin
         check("kind",  trc_kind_o,  q[0].kind);
         check("pc",    trc_pc_o,    q[0].pc);
         check("instr", trc_instr_o, q[0].instr);
         check("rd",    trc_rd_o,    q[0].rd);
         check("data",  trc_data_o,  q[0].data);
      end
      check("busy", busy_o, m_sweep);
      check("addr", addr_o, m_addr);
      check("overflow", overflow_o, m_ovf);
`ifdef TRACE_SINK_DROP_CNT_EN
      check("drop_cnt", drop_cnt_o, m_drops);
`endif
   endtask

   // Applies the sink's rules for one clock edge to the record queue.
   task automatic model_update();
      bit   was_busy, do_pop, cv, has_room;
      rec_t r;
      was_busy = m_sweep;
      do_pop   = (q.size() != 0) && trc_ready_i;
      cv       = !stall_i && (instr_i != 0);
      has_room = (q.size() < DEPTH) || do_pop;
      if (do_pop) void'(q.pop_front());
      if (cv) begin
         if (has_room) begin
            r.kind = 0; r.pc = pc_i; r.instr = instr_i; r.rd = reg_addr_i; r.data = reg_data_i;
            q.push_back(r);
         end else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
         end
      end else if (m_sweep && has_room) begin
         r.kind = 1; r.pc = m_addr; r.instr = 0; r.rd = 0; r.data = mem_word(m_addr);
         q.push_back(r);
         m_addr += 32'd4;
         m_rem--;
         if (m_rem == 0) m_sweep = 0;
      end
      if (!was_busy && dump_start_i && (dump_len_i != 0)) begin
         m_sweep = 1;
         m_addr  = dump_base_i & ~32'h3;
         m_rem   = dump_len_i;
      end
   endtask

   task automatic step();
      #1;
      check_outputs();
      model_update();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic set_idle();
      stall_i = 1'b1; instr_i = '0; pc_i = '0; reg_addr_i = '0; reg_data_i = '0;
      dump_start_i = 1'b0; dump_base_i = '0; dump_len_i = '0; trc_ready_i = 1'b1;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                         input logic [31:0] dat);
      stall_i = 1'b0; pc_i = pc; instr_i = ins; reg_addr_i = rd; reg_data_i = dat;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #2;
      model_clear();
      check("rst_valid", trc_valid_o, 1'b0);
      check("rst_trc", {trc_kind_o, trc_pc_o, trc_rd_o}, '0);
      check("rst_trc_iw", {trc_instr_o, trc_data_o}, '0);
      check("rst_addr", addr_o, '0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_ovf", overflow_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic drain();
      set_idle();
      for (int k = 0; k < 4*DEPTH && (trc_valid_o || busy_o); k++) step();
      check("drain_done", {trc_valid_o, busy_o}, 2'b00);
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      set_idle();
      rst_i = 1'b1;
      #3;
      do_reset();

      // 1: three retirements with consumer ready
      for (int i = 0; i < 3; i++) begin
         commit(32'(4*i), 32'h0050_0293 + 32'(i), 5'd5, 32'h11);
         step();
      end
      set_idle();
      repeat (3) step();

      // 2: consumer stalled, DEPTH+2 retirements
      trc_ready_i = 1'b0;
      for (int i = 0; i < DEPTH+2; i++) begin
         commit(32'h1000 + 32'(4*i), $urandom | 32'h1, 5'($urandom), $urandom);
         trc_ready_i = 1'b0;
         step();
      end
      set_idle();
      trc_ready_i = 1'b0;
      step();
      check("t2_ovf", overflow_o, 1'b1);
      check("t2_drops", m_drops, 2);
      drain();
      do_reset();

      // 3: sweep base 0x102, len 4, no commits
      dump_start_i = 1'b1; dump_base_i = 32'h102; dump_len_i = 16'd4;
      step();
      set_idle();
      check("t3_addr0", addr_o, 32'h100);
      for (int k = 0; k < 20 && busy_o; k++) step();
      check("t3_busy_end", busy_o, 1'b0);
      check("t3_addr_end", addr_o, 32'h110);
      drain();

      // 4: sweep len 8 with a commit every other cycle
      dump_start_i = 1'b1; dump_base_i = 32'h2000; dump_len_i = 16'd8;
      step();
      set_idle();
      for (int k = 0; k < 24; k++) begin
         set_idle();
         if (k % 2 == 0) commit(32'h300 + 32'(4*k), 32'h13 + 32'(k), 5'(k), 32'(k*7));
         step();
      end
      check("t4_busy_end", busy_o, 1'b0);
      check("t4_no_ovf", overflow_o, 1'b0);
      drain();

      // 5: full FIFO, pop and commit in the same cycle; then zero-length sweep request
      for (int i = 0; i < DEPTH; i++) begin
         commit(32'h500 + 32'(4*i), 32'hABC0 + 32'(i), 5'd1, 32'(i));
         trc_ready_i = 1'b0;
         step();
      end
      commit(32'h600, 32'h1234, 5'd2, 32'h99);
      trc_ready_i = 1'b1;
      step();
      check("t5_no_ovf", overflow_o, 1'b0);
      drain();
      dump_start_i = 1'b1; dump_len_i = 16'd0; dump_base_i = 32'h40;
      step();
      set_idle();
      step();
      check("t5_len0_busy", busy_o, 1'b0);

      // 6: reset mid-sweep with cnt=3
      dump_start_i = 1'b1; dump_base_i = 32'h800; dump_len_i = 16'd5;
      trc_ready_i = 1'b0;
      step();
      set_idle();
      trc_ready_i = 1'b0;
      step();
      step();
      check("t6_mid_busy", busy_o, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      check("t6_busy", busy_o, 1'b0);
      check("t6_valid", trc_valid_o, 1'b0);
      check("t6_addr", addr_o, '0);
      model_clear();
      @(negedge clk_i);
      rst_i = 1'b0;
      set_idle();
      step();

      // Random traffic
      for (int k = 0; k < 500; k++) begin
         set_idle();
         trc_ready_i = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 6) begin
            commit($urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, 5'($urandom), $urandom);
            stall_i = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 19) == 0) begin
            dump_start_i = 1'b1;
            dump_base_i  = $urandom;
            dump_len_i   = 16'($urandom_range(0, 6));
         end
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
